// File: rtl/fir_in_frontend_if.sv
// Pin-side and core-side signal bundle for the FIR input front end.
// The slave side is the front end itself. The master side is whatever drives
// the pads and consumes the strobes.
interface fir_in_frontend_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic [DATA_W-1:0] x_in;
  logic              valid_pin;
  logic              set_coeffs_pin;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic [DATA_W-1:0] coeff_data;
  logic [ADDR_W-1:0] coeff_addr;
  logic              coeff_we;
  logic              loading;
  logic              load_done;

  modport master (
    output x_in, valid_pin, set_coeffs_pin,
    input  sample_data, sample_valid, coeff_data, coeff_addr,
           coeff_we, loading, load_done
  );

  modport slave (
    input  x_in, valid_pin, set_coeffs_pin,
    output sample_data, sample_valid, coeff_data, coeff_addr,
           coeff_we, loading, load_done
  );
endinterface

// File: rtl/fir_in_frontend.sv
// FIR input front end. It synchronizes the raw valid / set_coeffs pins and
// turns their edges into one-cycle strobes. Each strobed byte is steered
// either to the sample port (RUN) or to the coefficient store (LOAD).
// Every output is registered, so no pin reaches an output combinationally.
module fir_in_frontend #(
  parameter int DATA_W = 8,
  parameter int N_TAPS = 4,
  parameter int ADDR_W = 2
) (
  input logic               clk,
  input logic               reset,
  fir_in_frontend_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_TAPS - 1);

  typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;

  // s1/s2 form the synchronizer and s3 is history for edge detection.
  logic [2:0] v_sync;
  logic [2:0] c_sync;

  logic v_rise, c_rise, c_fall;

  assign v_rise = v_sync[1] & ~v_sync[2];
  assign c_rise = c_sync[1] & ~c_sync[2];
  assign c_fall = ~c_sync[1] & c_sync[2];

  // Pin synchronizers plus history flop; they reset low, so a pin that is
  // already high at reset release shows up as a rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_sync <= '0;
      c_sync <= '0;
    end else begin
      v_sync <= {v_sync[1:0], bus.valid_pin};
      c_sync <= {c_sync[1:0], bus.set_coeffs_pin};
    end
  end

  // RUN/LOAD controller with registered strobes and data outputs.
  // In RUN, a load request beats a simultaneous valid edge.
  // In LOAD, an abort beats a simultaneous valid edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= RUN;
      idx              <= '0;
      bus.sample_data  <= '0;
      bus.sample_valid <= 1'b0;
      bus.coeff_data   <= '0;
      bus.coeff_addr   <= '0;
      bus.coeff_we     <= 1'b0;
      bus.loading      <= 1'b0;
      bus.load_done    <= 1'b0;
    end else begin
      bus.sample_valid <= 1'b0;
      bus.coeff_we     <= 1'b0;
      bus.load_done    <= 1'b0;
      case (state)
        RUN: begin
          if (c_rise) begin
            state       <= LOAD;
            idx         <= '0;
            bus.loading <= 1'b1;
          end else if (v_rise) begin
            bus.sample_data  <= bus.x_in;
            bus.sample_valid <= 1'b1;
          end
        end
        LOAD: begin
          if (c_fall) begin
            // Abort: coefficients already written stay in the store.
            state       <= RUN;
            idx         <= '0;
            bus.loading <= 1'b0;
          end else if (v_rise) begin
            bus.coeff_data <= bus.x_in;
            bus.coeff_addr <= idx;
            bus.coeff_we   <= 1'b1;
            if (idx == LAST_IDX) begin
              state         <= RUN;
              idx           <= '0;
              bus.loading   <= 1'b0;
              bus.load_done <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: begin
          state       <= RUN;
          idx         <= '0;
          bus.loading <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_in_frontend.sv
// Directed bench for fir_in_frontend: latency, sample path, coefficient
// load, abort, simultaneous edges, and reset mid-load.
module tb_fir_in_frontend;

  logic clk = 1'b0;
  logic reset;

  fir_in_frontend_if #(.DATA_W(8), .ADDR_W(2)) bus ();

  fir_in_frontend #(.DATA_W(8), .N_TAPS(4), .ADDR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Strobe log, sampled 1 time unit after each rising edge.
  int sv_cnt   = 0;
  int ld_cnt   = 0;
  int ldwe_cnt = 0;
  int ca_q[$];
  int cd_q[$];

  always @(posedge clk) begin
    #1;
    if (bus.sample_valid) sv_cnt++;
    if (bus.coeff_we) begin
      ca_q.push_back(int'(bus.coeff_addr));
      cd_q.push_back(int'(bus.coeff_data));
    end
    if (bus.load_done) begin
      ld_cnt++;
      if (bus.coeff_we) ldwe_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Checks logged coefficient write number i against an expected (addr, data).
  task automatic chk_coeff(input string tag, input int i, input int ea, input int ed);
    if (i < ca_q.size()) begin
      chk({tag, "_addr"}, ca_q[i], ea);
      chk({tag, "_data"}, cd_q[i], ed);
    end else begin
      chk({tag, "_missing"}, 32'hdead, ea);
    end
  endtask

  // Valid pin pulse: 4 cycles high, then 4 cycles low. x_in is held throughout.
  task automatic pulse_valid(input logic [7:0] d);
    @(negedge clk);
    bus.x_in      = d;
    bus.valid_pin = 1'b1;
    repeat (4) @(negedge clk);
    bus.valid_pin = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic set_pin(input logic v);
    @(negedge clk);
    bus.set_coeffs_pin = v;
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sdata"},  bus.sample_data,  0);
    chk({tag, "_svalid"}, bus.sample_valid, 0);
    chk({tag, "_cdata"},  bus.coeff_data,   0);
    chk({tag, "_caddr"},  bus.coeff_addr,   0);
    chk({tag, "_cwe"},    bus.coeff_we,     0);
    chk({tag, "_loading"}, bus.loading,     0);
    chk({tag, "_ldone"},  bus.load_done,    0);
  endtask

  int sv0, ld0, cq0;

  initial begin
    reset              = 1'b1;
    bus.x_in           = '0;
    bus.valid_pin      = 1'b0;
    bus.set_coeffs_pin = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Sample path latency: the strobe appears after the third rising edge
    // following the pin rise.
    cq0 = ca_q.size();
    bus.x_in      = 8'h5A;
    bus.valid_pin = 1'b1;
    @(posedge clk); #1 chk("lat_e1", bus.sample_valid, 0);
    @(posedge clk); #1 chk("lat_e2", bus.sample_valid, 0);
    @(posedge clk); #1 chk("lat_e3", bus.sample_valid, 1);
    chk("lat_data", bus.sample_data, 8'h5A);
    @(posedge clk); #1 chk("lat_e4", bus.sample_valid, 0);
    @(negedge clk);
    bus.valid_pin = 1'b0;
    repeat (4) @(negedge clk);
    chk("lat_no_cwe", ca_q.size() - cq0, 0);

    // Full coefficient load.
    sv0 = sv_cnt; ld0 = ld_cnt; cq0 = ca_q.size();
    set_pin(1'b1);
    chk("load_loading", bus.loading, 1);
    pulse_valid(8'h11);
    pulse_valid(8'h22);
    pulse_valid(8'h33);
    chk("load_loading3", bus.loading, 1);
    chk("load_ld_early", ld_cnt - ld0, 0);
    pulse_valid(8'h44);
    chk("load_nwe", ca_q.size() - cq0, 4);
    chk_coeff("load_c0", cq0 + 0, 0, 8'h11);
    chk_coeff("load_c1", cq0 + 1, 1, 8'h22);
    chk_coeff("load_c2", cq0 + 2, 2, 8'h33);
    chk_coeff("load_c3", cq0 + 3, 3, 8'h44);
    chk("load_done_cnt", ld_cnt - ld0, 1);
    chk("load_done_with_we", ldwe_cnt, 1);
    chk("load_loading_end", bus.loading, 0);
    chk("load_no_sv", sv_cnt - sv0, 0);

    // set_coeffs still high: no reload, valid goes to samples.
    sv0 = sv_cnt; cq0 = ca_q.size();
    pulse_valid(8'h77);
    chk("held_sv", sv_cnt - sv0, 1);
    chk("held_sdata", bus.sample_data, 8'h77);
    chk("held_loading", bus.loading, 0);
    chk("held_no_cwe", ca_q.size() - cq0, 0);

    // Abort after two coefficients.
    set_pin(1'b0);
    ld0 = ld_cnt; cq0 = ca_q.size(); sv0 = sv_cnt;
    set_pin(1'b1);
    chk("abort_loading", bus.loading, 1);
    pulse_valid(8'hA1);
    pulse_valid(8'hA2);
    set_pin(1'b0);
    chk("abort_loading_off", bus.loading, 0);
    chk("abort_no_done", ld_cnt - ld0, 0);
    chk_coeff("abort_c0", cq0 + 0, 0, 8'hA1);
    chk_coeff("abort_c1", cq0 + 1, 1, 8'hA2);
    pulse_valid(8'hB0);
    chk("abort_sv", sv_cnt - sv0, 1);
    chk("abort_sdata", bus.sample_data, 8'hB0);
    cq0 = ca_q.size();
    set_pin(1'b1);
    pulse_valid(8'hC0);
    chk_coeff("restart_c0", cq0, 0, 8'hC0);
    set_pin(1'b0);

    // Both pins rise in the same cycle: the valid edge is dropped.
    sv0 = sv_cnt; cq0 = ca_q.size();
    @(negedge clk);
    bus.x_in           = 8'hD0;
    bus.valid_pin      = 1'b1;
    bus.set_coeffs_pin = 1'b1;
    repeat (4) @(negedge clk);
    bus.valid_pin = 1'b0;
    repeat (4) @(negedge clk);
    chk("both_no_sv", sv_cnt - sv0, 0);
    chk("both_no_cwe", ca_q.size() - cq0, 0);
    chk("both_loading", bus.loading, 1);
    pulse_valid(8'hD1);
    chk_coeff("both_c0", cq0, 0, 8'hD1);
    pulse_valid(8'hD2);
    chk_coeff("both_c1", cq0 + 1, 1, 8'hD2);

    // Reset mid-load with valid_pin held high across reset release.
    @(negedge clk);
    reset              = 1'b1;
    bus.set_coeffs_pin = 1'b0;
    bus.valid_pin      = 1'b1;
    bus.x_in           = 8'hE5;
    #1 chk_all_zero("midrst");
    repeat (3) @(negedge clk);
    sv0 = sv_cnt; cq0 = ca_q.size();
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_sv", sv_cnt - sv0, 1);
    chk("rst_sdata", bus.sample_data, 8'hE5);
    chk("rst_loading", bus.loading, 0);
    chk("rst_no_cwe", ca_q.size() - cq0, 0);
    bus.valid_pin = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_in_frontend.md
# fir_in_frontend

Input front end for the FIR datapath. It takes the raw, asynchronous pad-level sample bus and the `valid` / `set_coeffs` control pins and synchronizes them. It turns pin rising edges into single-cycle strobes, and it routes each strobed byte either to the filter as a sample or to the coefficient register file as a coefficient write. The block sits between the top-level pin mapping and the FIR core: its sample outputs feed the core's sample port, and its coefficient outputs feed the core's coefficient store.

## Interface
- `DATA_W`, default 8, width of the sample/coefficient byte.
- `N_TAPS`, default 4, number of coefficients written per load sequence (≥1).
- `ADDR_W`, default 2, coefficient address width; must satisfy 2^ADDR_W ≥ N_TAPS.

Ports:
- `clk` input 1: single system clock; all flops use the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `x_in` input DATA_W: raw input byte from pins.
- `valid_pin` input 1: raw strobe pin, asynchronous to clk.
- `set_coeffs_pin` input 1: raw coefficient-load request pin, asynchronous to clk.
- `sample_data` output DATA_W: registered sample for the FIR core.
- `sample_valid` output 1: one-cycle strobe qualifying `sample_data`.
- `coeff_data` output DATA_W: registered coefficient value.
- `coeff_addr` output ADDR_W: coefficient index being written.
- `coeff_we` output 1: one-cycle coefficient write strobe.
- `loading` output 1: high while in LOAD state.
- `load_done` output 1: one-cycle pulse when all N_TAPS coefficients have been written.

## Operation
- Each of `valid_pin` and `set_coeffs_pin` has a 2-flop synchronizer (s1, s2) plus a history flop (s3).
- Rising edge is defined as `rise = s2 & ~s3`.
- Falling edge of set_coeffs is defined as `fall = ~s2 & s3`.
- State machine has two states: RUN (reset state) and LOAD. Address counter `idx` is ADDR_W bits.
- In RUN, with `set_coeffs` rise asserted, the next state is LOAD and `idx` is cleared to 0. A `valid` rise in the same cycle is dropped: no strobe of either kind.
- In RUN, with only a `valid` rise:
  - `sample_data` ← `x_in`.
  - `sample_valid` = 1 for one cycle.
- In LOAD, on a `valid` rise:
  - `coeff_data` ← `x_in`, `coeff_addr` ← `idx`.
  - `coeff_we` = 1 for one cycle.
  - `idx` ← `idx` + 1.
  - If `idx` == N_TAPS−1, `load_done` = 1 for one cycle, the next state is RUN, and `idx` ← 0.
- In LOAD, `sample_valid` never asserts.
- In LOAD, a `set_coeffs` fall (abort) returns the block to RUN with `idx` ← 0 and no `load_done`. Coefficients already written stay written.
- If a `set_coeffs` fall and a `valid` rise coincide in LOAD, the abort wins: no `coeff_we`.
- Load requests are edge-triggered. Holding `set_coeffs_pin` high after `load_done` does not restart a load. The pin must go low and high again.
- Samples are accepted in RUN regardless of the `set_coeffs` level.
- `sample_data` and `coeff_data` hold their last values between strobes.
- `loading` = (state == LOAD).

## Timing
- Reset values:
  - All synchronizer/history flops 0, state RUN, `idx` 0.
  - `sample_data`, `coeff_data`, `coeff_addr` all 0.
  - `sample_valid`, `coeff_we`, `loading`, `load_done` all 0.
- Because synchronizers reset to 0, a pin already high at reset release is seen as a rising edge.
- All outputs are registered. There is no combinational path from pins to outputs.
- Latency: a pin rise captured by s1 at edge k produces its strobe from the flops updated at edge k+2. The strobe is visible for the cycle after edge k+2: 3 edges from pin to strobe.
- `x_in` is sampled at edge k+2, so it must be stable from pin rise through 3 clock edges after it.
- Each pin must be held high ≥2 cycles and low ≥2 cycles between edges; shorter pulses may be missed.
- Maximum accept rate is one byte per 4 cycles.
- `loading` rises the cycle after the `set_coeffs` strobe edge and falls in the same cycle that `load_done` is high.
- `load_done` coincides with the final `coeff_we`.

## Test plan
- Reset, then `valid_pin` pulse (4 cycles high) with `x_in`=0x5A → `sample_valid` high exactly 1 cycle, 3 edges after the pin rise; `sample_data`=0x5A; `coeff_we` stays 0.
- `set_coeffs_pin` high, then 4 valid pulses with 0x11, 0x22, 0x33, 0x44 →
  - `loading`=1.
  - `coeff_we` pulses with (addr, data) = (0,11), (1,22), (2,33), (3,44).
  - `load_done` coincides with the 4th pulse, then `loading`=0.
  - No `sample_valid`.
- After the load above, keep `set_coeffs_pin` high and pulse valid with 0x77 → `sample_valid` with 0x77; no reload.
- Load aborted after 2 coefficients (pin falls) → state RUN, `load_done` never pulses; the next valid pulse yields `sample_valid`. A new set_coeffs rise restarts at `coeff_addr`=0.
- Both pins rise in the same clk cycle → no strobe; `loading`=1; the next valid pulse writes `coeff_addr`=0.
- Assert `reset` mid-load (after addr 1) → all outputs 0 immediately, state RUN; `valid_pin` held high through reset release → one `sample_valid`.
